// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART: FSM states, frame length, default divisor.
// No logic here.
package uart_pkg;

   localparam int FRAME_BITS       = 10;
   localparam int BAUD_DIV_DEFAULT = 2604;

   typedef enum logic {
      TX_IDLE     = 1'b0,
      TX_TRANSMIT = 1'b1
   } tx_state_t;

   typedef enum logic {
      RX_IDLE    = 1'b0,
      RX_RECEIVE = 1'b1
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous RX line; both flops reset to idle-high.
// Latency: 2 clocks. No backpressure.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART; define UART_STOP_CHECK_EN to drop frames whose stop bit reads 0.
// Latency: TX falls on the trmt edge, tx_done 10 bit periods later; rdy ~9.5 bit periods + 3 after RX falls.
// No backpressure: trmt is ignored while transmitting, an unread rx_data is overwritten.
module uart
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy
);

   localparam int             CW        = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0]  BAUD_HALF = CW'(BAUD_DIV / 2);
   localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

   // ---------------- transmit path ----------------
   tx_state_t     tx_state_q, tx_state_d;
   logic [9:0]    tx_shift_q, tx_shift_d;
   logic [CW-1:0] tx_baud_q,  tx_baud_d;
   logic [3:0]    tx_bit_q,   tx_bit_d;
   logic          tx_done_q,  tx_done_d;
   logic          tx_out_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_done_d  = tx_done_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (trmt) begin
               tx_shift_d = {1'b1, tx_data, 1'b0};
               tx_baud_d  = '0;
               tx_bit_d   = '0;
               tx_done_d  = 1'b0;
               tx_state_d = TX_TRANSMIT;
            end
         end
         TX_TRANSMIT: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = '0;
               tx_shift_d = {1'b1, tx_shift_q[9:1]};
               tx_bit_d   = tx_bit_q + 4'd1;
               if (tx_bit_q == LAST_BIT) begin
                  tx_state_d = TX_IDLE;
                  tx_done_d  = 1'b1;
               end
            end else begin
               tx_baud_d = tx_baud_q + CW'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // TX is the next shift LSB, registered, so the line changes on the same edge as the shifter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '1;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_done_q  <= 1'b0;
         tx_out_q   <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_done_q  <= tx_done_d;
         tx_out_q   <= tx_shift_d[0];
      end
   end

   assign TX      = tx_out_q;
   assign tx_done = tx_done_q;

   // ---------------- receive path ----------------
   rx_state_t     rx_state_q, rx_state_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [CW-1:0] rx_baud_q,  rx_baud_d;
   logic [3:0]    rx_bit_q,   rx_bit_d;
   logic [7:0]    rx_data_q,  rx_data_d;
   logic          rdy_q,      rdy_d;
   logic          rx_sync;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (RX),
      .q   (rx_sync)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_data_d  = rx_data_q;
      rdy_d      = rdy_q;
      if (clr_rdy) rdy_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_d = RX_RECEIVE;
               rx_baud_d  = BAUD_HALF;
               rx_bit_d   = '0;
               rdy_d      = 1'b0;
            end
         end
         RX_RECEIVE: begin
            if (rx_baud_q == '0) begin
               rx_baud_d  = BAUD_LAST;
               rx_bit_d   = rx_bit_q + 4'd1;
               // the start sample falls off the end; the stop sample is judged directly
               rx_shift_d = {rx_sync, rx_shift_q[7:1]};
               if (rx_bit_q == 4'd0 && rx_sync) begin
                  rx_state_d = RX_IDLE;
               end else if (rx_bit_q == LAST_BIT) begin
                  rx_state_d = RX_IDLE;
                  rx_shift_d = rx_shift_q;
`ifdef UART_STOP_CHECK_EN
                  if (rx_sync) begin
                     rx_data_d = rx_shift_q;
                     rdy_d     = 1'b1;
                  end
`else
                  rx_data_d = rx_shift_q;
                  rdy_d     = 1'b1;
`endif
               end
            end else begin
               rx_baud_d = rx_baud_q - CW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_data_q  <= '0;
         rdy_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_data_q  <= rx_data_d;
         rdy_q      <= rdy_d;
      end
   end

   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;

endmodule

// File: tb/tb_uart.sv
// Bench for uart: a full-rate loopback instance plus a fast-divisor instance for the longer scenarios.
// Expected bytes go into a scoreboard queue on trmt and are popped when rdy rises.
module tb_uart;
   import uart_pkg::*;

   localparam int BDS = 2604;
   localparam int BDF = 24;

   logic       clk = 1'b0;
   logic       rst;

   logic       s_trmt, s_tx, s_tx_done, s_clr_rdy, s_rdy;
   logic [7:0] s_tx_data, s_rx_data;

   logic       f_trmt, f_tx, f_tx_done, f_clr_rdy, f_rdy, f_rx, f_rx_drv, f_loop;
   logic [7:0] f_tx_data, f_rx_data;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] sb[$];
   logic [7:0] last_good;

   always #5 clk = ~clk;

   assign f_rx = f_loop ? f_tx : f_rx_drv;

   uart #(.BAUD_DIV(BDS)) u_slow (
      .clk(clk), .rst(rst), .trmt(s_trmt), .tx_data(s_tx_data), .TX(s_tx), .tx_done(s_tx_done),
      .RX(s_tx), .clr_rdy(s_clr_rdy), .rx_data(s_rx_data), .rdy(s_rdy));

   uart #(.BAUD_DIV(BDF)) u_fast (
      .clk(clk), .rst(rst), .trmt(f_trmt), .tx_data(f_tx_data), .TX(f_tx), .tx_done(f_tx_done),
      .RX(f_rx), .clr_rdy(f_clr_rdy), .rx_data(f_rx_data), .rdy(f_rdy));

   // One fast-instance frame; optionally pulses trmt=0x33 mid-frame. Returns observations only.
   task automatic xfer(input logic [7:0] b, input int mid_at, output bit fell, output int cyc,
                       output bit got, output logic [7:0] rxd);
      f_tx_data = b;
      f_trmt    = 1'b1;
      sb.push_back(b);
      @(negedge clk);
      f_trmt = 1'b0;
      fell   = (f_tx === 1'b0);
      cyc    = 0;
      got    = 1'b0;
      rxd    = 8'h00;
      while (f_tx_done !== 1'b1 && cyc < 20 * BDF) begin
         @(negedge clk);
         cyc++;
         f_clr_rdy = 1'b0;
         f_trmt    = 1'b0;
         if (cyc == mid_at) begin
            f_tx_data = 8'h33;
            f_trmt    = 1'b1;
         end
         if (f_rdy === 1'b1 && !got) begin
            got       = 1'b1;
            rxd       = f_rx_data;
            f_clr_rdy = 1'b1;
         end
      end
      f_clr_rdy = 1'b0;
      f_trmt    = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      s_trmt = 1'b0; s_tx_data = 8'h00; s_clr_rdy = 1'b0;
      f_trmt = 1'b0; f_tx_data = 8'h00; f_clr_rdy = 1'b0; f_rx_drv = 1'b1; f_loop = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (s_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", s_tx); end
      checks++; if (s_tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done got=%b exp=0", s_tx_done); end
      checks++; if (s_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", s_rdy); end
      checks++; if (s_rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", s_rx_data); end
      checks++; if (f_tx !== 1'b1) begin failures++; $display("FAIL reset_f_tx got=%b exp=1", f_tx); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_loopback_slow;
      int n, rdy_at, done_at;
      logic [7:0] exp;
      s_tx_data = 8'h6A;
      s_trmt    = 1'b1;
      sb.push_back(8'h6A);
      @(negedge clk);
      s_trmt  = 1'b0;
      n       = 0;
      rdy_at  = -1;
      done_at = -1;
      while ((rdy_at < 0 || done_at < 0) && n < 100000) begin
         @(negedge clk);
         n++;
         if (s_rdy === 1'b1 && rdy_at < 0) rdy_at = n;
         if (s_tx_done === 1'b1 && done_at < 0) done_at = n;
      end
      exp = sb.pop_front();
      checks++; if (rdy_at < 0) begin failures++; $display("FAIL slow_rdy_timeout got=none exp=rise"); end
      checks++; if (done_at != 10 * BDS) begin failures++; $display("FAIL slow_tx_done_time got=%0d exp=%0d", done_at, 10 * BDS); end
      checks++; if (!(rdy_at >= 9 * BDS && rdy_at < done_at)) begin failures++; $display("FAIL slow_rdy_order got=%0d exp=before %0d", rdy_at, done_at); end
      checks++; if (s_rx_data !== exp) begin failures++; $display("FAIL slow_rx_data got=%h exp=%h", s_rx_data, exp); end
   endtask

   task automatic test_clr_rdy;
      checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL clr_rdy_pre got=%b exp=1", s_rdy); end
      s_clr_rdy = 1'b1;
      @(negedge clk);
      s_clr_rdy = 1'b0;
      checks++; if (s_rdy !== 1'b0) begin failures++; $display("FAIL clr_rdy_post got=%b exp=0", s_rdy); end
      checks++; if (s_rx_data !== 8'h6A) begin failures++; $display("FAIL clr_rdy_data got=%h exp=6a", s_rx_data); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] pats [4];
      bit fell, got;
      int cyc;
      logic [7:0] rxd, exp;
      pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h55; pats[3] = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         xfer(pats[i], -1, fell, cyc, got, rxd);
         exp = sb.pop_front();
         checks++; if (!fell) begin failures++; $display("FAIL b2b_tx_fall[%0d] got=high exp=low", i); end
         checks++; if (cyc != 10 * BDF) begin failures++; $display("FAIL b2b_tx_done_time[%0d] got=%0d exp=%0d", i, cyc, 10 * BDF); end
         checks++; if (!got) begin failures++; $display("FAIL b2b_rdy[%0d] got=none exp=rise", i); end
         checks++; if (rxd !== exp) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rxd, exp); end
      end
   endtask

   task automatic test_ignore_trmt;
      bit fell, got, rdy_seen;
      int cyc, lows;
      logic [7:0] rxd, exp;
      xfer(8'hC3, 3 * BDF, fell, cyc, got, rxd);
      exp = sb.pop_front();
      checks++; if (!got || rxd !== exp) begin failures++; $display("FAIL ignore_data got=%h exp=%h", rxd, exp); end
      checks++; if (cyc != 10 * BDF) begin failures++; $display("FAIL ignore_time got=%0d exp=%0d", cyc, 10 * BDF); end
      last_good = exp;
      lows = 0;
      rdy_seen = 1'b0;
      repeat (12 * BDF) begin
         @(negedge clk);
         if (f_tx !== 1'b1) lows++;
         if (f_rdy === 1'b1) rdy_seen = 1'b1;
      end
      checks++; if (lows != 0) begin failures++; $display("FAIL ignore_second_frame got=%0d low cycles exp=0", lows); end
      checks++; if (rdy_seen) begin failures++; $display("FAIL ignore_second_rdy got=1 exp=0"); end
   endtask

   task automatic test_glitch;
      bit rdy_seen;
      f_rx_drv = 1'b1;
      f_loop   = 1'b0;
      repeat (4) @(negedge clk);
      f_rx_drv = 1'b0;
      repeat (BDF / 4) @(negedge clk);
      f_rx_drv = 1'b1;
      rdy_seen = 1'b0;
      repeat (2 * BDF) begin
         @(negedge clk);
         if (f_rdy === 1'b1) rdy_seen = 1'b1;
      end
      checks++; if (rdy_seen) begin failures++; $display("FAIL glitch_rdy got=1 exp=0"); end
      checks++; if (u_fast.rx_state_q !== RX_IDLE) begin failures++; $display("FAIL glitch_state got=%b exp=%b", u_fast.rx_state_q, RX_IDLE); end
   endtask

   task automatic test_stop_bit;
      logic [9:0] bits;
      bit seen;
      logic [7:0] seen_data;
      bits = {1'b0, 8'h5A, 1'b0};
      seen = 1'b0;
      seen_data = 8'h00;
      for (int i = 0; i < 10; i++) begin
         f_rx_drv = bits[i];
         repeat (BDF) begin
            @(negedge clk);
            if (f_rdy === 1'b1 && !seen) begin seen = 1'b1; seen_data = f_rx_data; end
         end
      end
      f_rx_drv = 1'b1;
      repeat (2 * BDF) begin
         @(negedge clk);
         if (f_rdy === 1'b1 && !seen) begin seen = 1'b1; seen_data = f_rx_data; end
      end
`ifdef UART_STOP_CHECK_EN
      checks++; if (seen) begin failures++; $display("FAIL stop_bad_rdy got=1 exp=0"); end
      checks++; if (f_rx_data !== last_good) begin failures++; $display("FAIL stop_bad_data got=%h exp=%h", f_rx_data, last_good); end
`else
      sb.push_back(8'h5A);
      checks++; if (!seen) begin failures++; $display("FAIL stop_nocheck_rdy got=0 exp=1"); end
      checks++; if (seen_data !== sb.pop_front()) begin failures++; $display("FAIL stop_nocheck_data got=%h exp=5a", seen_data); end
`endif
      f_loop = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame;
      int lows;
      bit rdy_seen, done_seen;
      f_tx_data = 8'h81;
      f_trmt    = 1'b1;
      sb.push_back(8'h81);
      @(negedge clk);
      f_trmt = 1'b0;
      repeat (4 * BDF) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (f_tx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", f_tx); end
      checks++; if (f_tx_done !== 1'b0) begin failures++; $display("FAIL midrst_tx_done got=%b exp=0", f_tx_done); end
      checks++; if (f_rdy !== 1'b0) begin failures++; $display("FAIL midrst_rdy got=%b exp=0", f_rdy); end
      checks++; if (f_rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", f_rx_data); end
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_front());
      lows = 0; rdy_seen = 1'b0; done_seen = 1'b0;
      repeat (12 * BDF) begin
         @(negedge clk);
         if (f_tx !== 1'b1) lows++;
         if (f_rdy === 1'b1) rdy_seen = 1'b1;
         if (f_tx_done === 1'b1) done_seen = 1'b1;
      end
      checks++; if (lows != 0 || rdy_seen || done_seen) begin
         failures++; $display("FAIL midrst_abort got=lows %0d rdy %b done %b exp=0 0 0", lows, rdy_seen, done_seen);
      end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      last_good = 8'h00;
      test_reset();
      test_loopback_slow();
      test_clr_rdy();
      test_back_to_back();
      test_ignore_trmt();
      test_glitch();
      test_stop_bit();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
